// File: rtl/video_filter_line_ctrl_pkg.sv
// Shared state type and size helpers for the 2-D filter line sequencer.
package video_filter_line_ctrl_pkg;

    localparam int DEF_FILTER_CORE_DIM = 5;
    localparam int DEF_MAX_WIDTH       = 2048;
    localparam int DEF_MAX_HEIGHT      = 2048;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        DRAIN    = 2'd2
    } line_state_t;

    // Number of line buffers: the current line streams live, the rest are stored.
    function automatic int calc_nbuf(input int dim);
        return dim - 1;
    endfunction

    // Distance from an edge inside which the kernel overhangs the image.
    function automatic int calc_half(input int dim);
        return (dim - 1) / 2;
    endfunction

    // Coordinate width for a given maximum extent (XW / YW).
    function automatic int calc_w(input int max_extent);
        return $clog2(max_extent);
    endfunction

    // Buffer index width, kept at least one bit wide.
    function automatic int calc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_line_rotator.sv
// Tracks which line buffer takes the current line, how many lines are stored,
// and which stored buffer holds the oldest kernel row.
module video_line_rotator
    import video_filter_line_ctrl_pkg::*;
#(
    parameter  int NBUF = 4,
    localparam int RW   = calc_idx_w(NBUF),
    localparam int LFW  = $clog2(NBUF + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            restart,
    input  logic            advance,
    output logic [NBUF-1:0] beat_sel,
    output logic [RW-1:0]   beat_rot,
    output logic            beat_full
);

    localparam logic [RW-1:0]  LAST_IDX = RW'(NBUF - 1);
    localparam logic [RW-1:0]  STEP_IDX = RW'(1);
    localparam logic [LFW-1:0] FULL_CNT = LFW'(NBUF);
    localparam logic [LFW-1:0] STEP_CNT = LFW'(1);

    logic [RW-1:0]  wr_idx, wr_idx_next, idx_base;
    logic [RW-1:0]  rot, rot_next, rot_base;
    logic [LFW-1:0] filled, filled_next, filled_base;

    // A restart clears the history first, so a line end on the same beat counts from zero.
    always_comb begin
        idx_base    = restart ? '0 : wr_idx;
        rot_base    = restart ? '0 : rot;
        filled_base = restart ? '0 : filled;
        wr_idx_next = idx_base;
        rot_next    = rot_base;
        filled_next = filled_base;
        if (advance) begin
            wr_idx_next = (idx_base == LAST_IDX) ? '0 : idx_base + STEP_IDX;
            if (filled_base == FULL_CNT) begin
                rot_next = (rot_base == LAST_IDX) ? '0 : rot_base + STEP_IDX;
            end else begin
                filled_next = filled_base + STEP_CNT;
            end
        end
        beat_sel  = NBUF'(1) << idx_base;
        beat_rot  = rot_base;
        beat_full = (filled_base == FULL_CNT);
    end

    // Rotation state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx <= '0;
            rot    <= '0;
            filled <= '0;
        end else begin
            wr_idx <= wr_idx_next;
            rot    <= rot_next;
            filled <= filled_next;
        end
    end

endmodule

// File: rtl/video_filter_line_ctrl.sv
// Line/frame sequencer for the streaming 2-D filter: follows accepted beats,
// drives line-buffer controls, window qualifier, border flags and framing errors.
module video_filter_line_ctrl
    import video_filter_line_ctrl_pkg::*;
#(
    parameter  int FILTER_CORE_DIM = DEF_FILTER_CORE_DIM,
    parameter  int MAX_WIDTH       = DEF_MAX_WIDTH,
    parameter  int MAX_HEIGHT      = DEF_MAX_HEIGHT,
    localparam int NBUF            = calc_nbuf(FILTER_CORE_DIM),
    localparam int HALF            = calc_half(FILTER_CORE_DIM),
    localparam int XW              = calc_w(MAX_WIDTH),
    localparam int YW              = calc_w(MAX_HEIGHT),
    localparam int RW              = calc_idx_w(NBUF)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tvalid,
    input  logic            s_tready,
    input  logic            s_tuser,
    input  logic            s_tlast,
    input  logic [XW:0]     cfg_width,
    input  logic [YW:0]     cfg_height,
    output logic            lb_wr_en,
    output logic [NBUF-1:0] lb_wr_sel,
    output logic [XW-1:0]   lb_wr_addr,
    output logic [RW-1:0]   lb_rot,
    output logic [XW-1:0]   pix_x,
    output logic [YW-1:0]   pix_y,
    output logic            win_valid,
    output logic            bord_l,
    output logic            bord_r,
    output logic            bord_t,
    output logic            bord_b,
    output logic            frame_done,
    output logic            err_eol_early,
    output logic            err_eol_late,
    output logic            err_sof,
    output logic            cfg_err
);

    localparam logic [XW:0]   DIM_X   = (XW+1)'(FILTER_CORE_DIM);
    localparam logic [XW:0]   MAXW_X  = (XW+1)'(MAX_WIDTH);
    localparam logic [XW:0]   HALF_X  = (XW+1)'(HALF);
    localparam logic [XW:0]   ONE_X   = (XW+1)'(1);
    localparam logic [XW-1:0] WIN_X   = XW'(FILTER_CORE_DIM - 1);
    localparam logic [XW-1:0] HALF_XS = XW'(HALF);
    localparam logic [XW-1:0] STEP_X  = XW'(1);
    localparam logic [YW:0]   DIM_Y   = (YW+1)'(FILTER_CORE_DIM);
    localparam logic [YW:0]   MAXH_Y  = (YW+1)'(MAX_HEIGHT);
    localparam logic [YW:0]   HALF_Y  = (YW+1)'(HALF);
    localparam logic [YW:0]   ONE_Y   = (YW+1)'(1);
    localparam logic [YW-1:0] HALF_YS = YW'(HALF);
    localparam logic [YW-1:0] STEP_Y  = YW'(1);

    line_state_t     state, state_next;
    logic [XW-1:0]   cur_x, cur_x_next, beat_x;
    logic [YW-1:0]   cur_y, cur_y_next, beat_y;
    logic [XW:0]     shd_w, shd_w_next, bw;
    logic [YW:0]     shd_h, shd_h_next, bh;
    logic            xfer, cfg_ok, cfg_err_next;
    logic            beat_wr, restart, eol, e_early, e_late, e_sof, done;
    logic            win_next, bl_next, br_next, bt_next, bb_next;
    logic [NBUF-1:0] rot_sel;
    logic [RW-1:0]   rot_oldest;
    logic            rot_full;

    video_line_rotator #(
        .NBUF(NBUF)
    ) u_rotator (
        .clk      (clk),
        .reset    (reset),
        .restart  (restart),
        .advance  (eol),
        .beat_sel (rot_sel),
        .beat_rot (rot_oldest),
        .beat_full(rot_full)
    );

    // Next state and per-beat decisions; a SOF beat uses the freshly sampled geometry.
    always_comb begin
        xfer         = s_tvalid && s_tready;
        cfg_ok       = (cfg_width >= DIM_X) && (cfg_width <= MAXW_X) &&
                       (cfg_height >= DIM_Y) && (cfg_height <= MAXH_Y);
        state_next   = state;
        cur_x_next   = cur_x;
        cur_y_next   = cur_y;
        shd_w_next   = shd_w;
        shd_h_next   = shd_h;
        cfg_err_next = cfg_err;
        beat_wr      = 1'b0;
        restart      = 1'b0;
        eol          = 1'b0;
        e_early      = 1'b0;
        e_late       = 1'b0;
        e_sof        = 1'b0;
        done         = 1'b0;
        beat_x       = cur_x;
        beat_y       = cur_y;
        bw           = shd_w;
        bh           = shd_h;
        if (xfer) begin
            if (s_tuser) begin
                e_sof        = (state != WAIT_SOF) && ((cur_x != '0) || (cur_y != '0));
                cfg_err_next = !cfg_ok;
                if (cfg_ok) begin
                    restart    = 1'b1;
                    beat_wr    = 1'b1;
                    beat_x     = '0;
                    beat_y     = '0;
                    bw         = cfg_width;
                    bh         = cfg_height;
                    shd_w_next = cfg_width;
                    shd_h_next = cfg_height;
                    cur_x_next = '0;
                    cur_y_next = '0;
                    state_next = ACTIVE;
                end else begin
                    state_next = WAIT_SOF;
                end
            end else if (state == ACTIVE) begin
                beat_wr = 1'b1;
            end else if (state == DRAIN) begin
                eol = s_tlast;
            end
            if (beat_wr) begin
                if (s_tlast) begin
                    eol     = 1'b1;
                    e_early = ({1'b0, beat_x} != (bw - ONE_X));
                end else if ({1'b0, beat_x} == (bw - ONE_X)) begin
                    e_late     = 1'b1;
                    state_next = DRAIN;
                end else begin
                    cur_x_next = beat_x + STEP_X;
                end
            end
            if (eol) begin
                cur_x_next = '0;
                if ({1'b0, beat_y} == (bh - ONE_Y)) begin
                    done       = 1'b1;
                    cur_y_next = '0;
                    state_next = WAIT_SOF;
                end else begin
                    cur_y_next = beat_y + STEP_Y;
                    state_next = ACTIVE;
                end
            end
        end
    end

    // Window qualifier and border flags for the beat being written.
    always_comb begin
        win_next = beat_wr && rot_full && (beat_x >= WIN_X);
        bl_next  = beat_x < HALF_XS;
        br_next  = {1'b0, beat_x} >= (bw - HALF_X);
        bt_next  = beat_y < HALF_YS;
        bb_next  = {1'b0, beat_y} >= (bh - HALF_Y);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT_SOF;
        end else begin
            state <= state_next;
        end
    end

    // Position counters and geometry shadowed at the last good SOF.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_x <= '0;
            cur_y <= '0;
            shd_w <= '0;
            shd_h <= '0;
        end else begin
            cur_x <= cur_x_next;
            cur_y <= cur_y_next;
            shd_w <= shd_w_next;
            shd_h <= shd_h_next;
        end
    end

    // Registered beat outputs; beat descriptors hold between writes, strobes clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lb_wr_en      <= 1'b0;
            lb_wr_sel     <= '0;
            lb_wr_addr    <= '0;
            lb_rot        <= '0;
            pix_x         <= '0;
            pix_y         <= '0;
            win_valid     <= 1'b0;
            bord_l        <= 1'b0;
            bord_r        <= 1'b0;
            bord_t        <= 1'b0;
            bord_b        <= 1'b0;
            frame_done    <= 1'b0;
            err_eol_early <= 1'b0;
            err_eol_late  <= 1'b0;
            err_sof       <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            lb_wr_en      <= beat_wr;
            win_valid     <= win_next;
            frame_done    <= done;
            err_eol_early <= e_early;
            err_eol_late  <= e_late;
            err_sof       <= e_sof;
            cfg_err       <= cfg_err_next;
            if (beat_wr) begin
                lb_wr_sel  <= rot_sel;
                lb_wr_addr <= beat_x;
                lb_rot     <= rot_oldest;
                pix_x      <= beat_x;
                pix_y      <= beat_y;
                bord_l     <= bl_next;
                bord_r     <= br_next;
                bord_t     <= bt_next;
                bord_b     <= bb_next;
            end
        end
    end

endmodule

// File: tb/tb_video_filter_line_ctrl.sv
// Directed bench for the filter line sequencer with FILTER_CORE_DIM=5, 2048x2048 limits.
module tb_video_filter_line_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_tvalid, s_tready, s_tuser, s_tlast;
    logic [11:0] cfg_width, cfg_height;
    logic        lb_wr_en;
    logic [3:0]  lb_wr_sel;
    logic [10:0] lb_wr_addr;
    logic [1:0]  lb_rot;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        win_valid, bord_l, bord_r, bord_t, bord_b;
    logic        frame_done, err_eol_early, err_eol_late, err_sof, cfg_err;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_w    = 8;
    int exp_h    = 6;

    video_filter_line_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tuser      (s_tuser),
        .s_tlast      (s_tlast),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .lb_wr_en     (lb_wr_en),
        .lb_wr_sel    (lb_wr_sel),
        .lb_wr_addr   (lb_wr_addr),
        .lb_rot       (lb_rot),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .win_valid    (win_valid),
        .bord_l       (bord_l),
        .bord_r       (bord_r),
        .bord_t       (bord_t),
        .bord_b       (bord_b),
        .frame_done   (frame_done),
        .err_eol_early(err_eol_early),
        .err_eol_late (err_eol_late),
        .err_sof      (err_sof),
        .cfg_err      (cfg_err)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d required %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of stream signals and sample outputs 1 ns after the edge.
    task automatic applyStimulus(input logic v, input logic r, input logic u, input logic l);
        s_tvalid = v;
        s_tready = r;
        s_tuser  = u;
        s_tlast  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle();
        checkOutput("idle_wr_en", lb_wr_en, 0);
        checkOutput("idle_win_valid", win_valid, 0);
        checkOutput("idle_frame_done", frame_done, 0);
        checkOutput("idle_err_early", err_eol_early, 0);
        checkOutput("idle_err_late", err_eol_late, 0);
    endtask

    // Sends n beats of row y starting at column x0 and checks each written beat.
    task automatic sendLine(input int y, input int x0, input int n, input bit sof, input bit last, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int x;
            bit fin;
            x   = x0 + i;
            fin = (i == n - 1);
            if (gaps) begin
                int k;
                k = $urandom_range(0, 2);
                for (int g = 0; g < k; g++) begin
                    int p;
                    p = $urandom_range(0, 2);
                    applyStimulus(p == 0, p == 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    checkIdle();
                end
            end
            applyStimulus(1'b1, 1'b1, sof && (i == 0), last && fin);
            checkOutput("wr_en", lb_wr_en, 1);
            checkOutput("pix_x", pix_x, x);
            checkOutput("wr_addr", lb_wr_addr, x);
            checkOutput("pix_y", pix_y, y);
            checkOutput("wr_sel", lb_wr_sel, 32'(1) << (y % 4));
            checkOutput("lb_rot", lb_rot, (y <= 4) ? 0 : (y - 4) % 4);
            checkOutput("win_valid", win_valid, (y >= 4) && (x >= 4));
            checkOutput("bord_l", bord_l, x < 2);
            checkOutput("bord_r", bord_r, x >= exp_w - 2);
            checkOutput("bord_t", bord_t, y < 2);
            checkOutput("bord_b", bord_b, y >= exp_h - 2);
            checkOutput("err_eol_early", err_eol_early, last && fin && (x != exp_w - 1));
            checkOutput("err_eol_late", err_eol_late, !(last && fin) && (x == exp_w - 1));
            checkOutput("frame_done", frame_done, last && fin && (y == exp_h - 1));
            checkOutput("err_sof", err_sof, 0);
        end
    endtask

    // Directed test sequence.
    initial begin
        reset      = 1'b1;
        s_tvalid   = 1'b0;
        s_tready   = 1'b0;
        s_tuser    = 1'b0;
        s_tlast    = 1'b0;
        cfg_width  = 12'd8;
        cfg_height = 12'd6;
        #3;
        checkOutput("rst_wr_en", lb_wr_en, 0);
        checkOutput("rst_pix_x", pix_x, 0);
        checkOutput("rst_wr_sel", lb_wr_sel, 0);
        checkOutput("rst_cfg_err", cfg_err, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] clean 8x6 frame, continuous valid");
        for (int y = 0; y < 6; y++) sendLine(y, 0, 8, y == 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkIdle();

        $display("[TB] same frame with tvalid/tready gaps");
        for (int y = 0; y < 6; y++) sendLine(y, 0, 8, y == 0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkIdle();

        $display("[TB] early tlast at x=5 on line 2");
        sendLine(0, 0, 8, 1'b1, 1'b1, 1'b0);
        sendLine(1, 0, 8, 1'b0, 1'b1, 1'b0);
        sendLine(2, 0, 6, 1'b0, 1'b1, 1'b0);
        checkOutput("early_pulse", err_eol_early, 1);
        for (int y = 3; y < 6; y++) sendLine(y, 0, 8, 1'b0, 1'b1, 1'b0);
        checkOutput("early_frame_done", frame_done, 1);

        $display("[TB] missing tlast at x=7 on line 1");
        sendLine(0, 0, 8, 1'b1, 1'b1, 1'b0);
        sendLine(1, 0, 8, 1'b0, 1'b0, 1'b0);
        checkOutput("late_pulse", err_eol_late, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("drain1_wr_en", lb_wr_en, 0);
        checkOutput("drain1_late", err_eol_late, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("drain2_wr_en", lb_wr_en, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("drain3_wr_en", lb_wr_en, 0);
        checkOutput("drain3_done", frame_done, 0);
        for (int y = 2; y < 6; y++) sendLine(y, 0, 8, 1'b0, 1'b1, 1'b0);

        $display("[TB] SOF at (3,2) restarts the frame");
        sendLine(0, 0, 8, 1'b1, 1'b1, 1'b0);
        sendLine(1, 0, 8, 1'b0, 1'b1, 1'b0);
        sendLine(2, 0, 3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("sof_err", err_sof, 1);
        checkOutput("sof_wr_en", lb_wr_en, 1);
        checkOutput("sof_pix_x", pix_x, 0);
        checkOutput("sof_pix_y", pix_y, 0);
        checkOutput("sof_rot", lb_rot, 0);
        checkOutput("sof_sel", lb_wr_sel, 1);
        checkOutput("sof_win", win_valid, 0);
        sendLine(0, 1, 7, 1'b0, 1'b1, 1'b0);
        for (int y = 1; y < 6; y++) sendLine(y, 0, 8, 1'b0, 1'b1, 1'b0);

        $display("[TB] invalid geometry rejected, then recovery");
        cfg_width = 12'd4;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("cfgw_err", cfg_err, 1);
        checkOutput("cfgw_wr_en", lb_wr_en, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("cfgw_beat_wr_en", lb_wr_en, 0);
        checkOutput("cfgw_err_hold", cfg_err, 1);
        cfg_width  = 12'd8;
        cfg_height = 12'd4;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("cfgh_err", cfg_err, 1);
        checkOutput("cfgh_wr_en", lb_wr_en, 0);
        cfg_width  = 12'd5;
        cfg_height = 12'd5;
        exp_w      = 5;
        exp_h      = 5;
        sendLine(0, 0, 5, 1'b1, 1'b1, 1'b0);
        checkOutput("cfg_ok_err", cfg_err, 0);
        sendLine(1, 0, 3, 1'b0, 1'b0, 1'b0);

        $display("[TB] asynchronous reset mid-line");
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_wr_en", lb_wr_en, 0);
        checkOutput("arst_wr_sel", lb_wr_sel, 0);
        checkOutput("arst_wr_addr", lb_wr_addr, 0);
        checkOutput("arst_pix_x", pix_x, 0);
        checkOutput("arst_pix_y", pix_y, 0);
        checkOutput("arst_rot", lb_rot, 0);
        checkOutput("arst_win", win_valid, 0);
        checkOutput("arst_bord_l", bord_l, 0);
        checkOutput("arst_bord_t", bord_t, 0);
        checkOutput("arst_cfg_err", cfg_err, 0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("post_rst_wr_en", lb_wr_en, 0);
        checkOutput("post_rst_pix_x", pix_x, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
